// File: rtl/syn_sram_mem_pkg.sv
// Shared types and constants for the multi-agent async SRAM controller.
package syn_sram_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR,
    WR_HOLD,
    TURN
  } state_t;

  localparam int SRAM_ADDR_W = 18;
  localparam int SRAM_DATA_W = 16;

  // Width of an agent index; a single agent still gets one bit.
  function automatic int agent_id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/syn_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester at or after i_ptr.
module syn_rr_arbiter #(
  parameter int NUM_AGENTS = 2,
  parameter int PTR_W      = 1
) (
  input  logic [NUM_AGENTS-1:0] i_req,
  input  logic [PTR_W-1:0]      i_ptr,
  output logic [NUM_AGENTS-1:0] o_grant
);

  logic w_found;

  // Outer loop walks priority order starting at the pointer; inner loop maps offset to agent.
  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    for (int i = 0; i < NUM_AGENTS; i++) begin
      for (int j = 0; j < NUM_AGENTS; j++) begin
        if (!w_found && i_req[j] && (((int'(i_ptr) + i) % NUM_AGENTS) == j)) begin
          o_grant[j] = 1'b1;
          w_found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/syn_sram_mem_ctrl.sv
// Multi-agent round-robin controller for an asynchronous 256Kx16 SRAM with registered pin drive.
// Optional macro SYN_SRAM_MEM_CTRL_TURNAROUND_EN inserts a one-cycle TURN state after each access.
module syn_sram_mem_ctrl
  import syn_sram_mem_pkg::*;
#(
  parameter int NUM_AGENTS = 2,
  parameter int ADDR_W     = SRAM_ADDR_W,
  parameter int DATA_W     = SRAM_DATA_W,
  parameter int BE_W       = DATA_W / 8,
  parameter int RD_CYCLES  = 2,
  parameter int WR_CYCLES  = 2
) (
  input  logic                                clk_ir,
  input  logic                                rst_il,
  input  logic [NUM_AGENTS-1:0]               agt_rd_en_i,
  input  logic [NUM_AGENTS-1:0]               agt_wr_en_i,
  input  logic [NUM_AGENTS*ADDR_W-1:0]        agt_addr_i,
  input  logic [NUM_AGENTS*DATA_W-1:0]        agt_wdata_i,
  input  logic [NUM_AGENTS*BE_W-1:0]          agt_be_i,
  output logic [NUM_AGENTS-1:0]               agt_ack_o,
  output logic                                rd_valid_o,
  output logic [agent_id_w(NUM_AGENTS)-1:0]   rd_agent_o,
  output logic [DATA_W-1:0]                   rd_data_o,
  output logic [ADDR_W-1:0]                   SRAM_ADDR,
  output logic [BE_W-1:0]                     SRAM_BE_N,
  output logic                                SRAM_CE_N,
  output logic                                SRAM_OE_N,
  output logic                                SRAM_WE_N,
  output logic [DATA_W-1:0]                   sram_dq_o,
  output logic                                sram_dq_oe_o,
  input  logic [DATA_W-1:0]                   sram_dq_i
);

  localparam int AID_W   = agent_id_w(NUM_AGENTS);
  localparam int MAX_CYC = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

`ifdef SYN_SRAM_MEM_CTRL_TURNAROUND_EN
  localparam state_t POST_ACCESS = TURN;
`else
  localparam state_t POST_ACCESS = IDLE;
`endif

  state_t                  r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [AID_W-1:0]        r_ptr;
  logic [AID_W-1:0]        r_agent;
  logic [BE_W-1:0]         r_be;
  logic [ADDR_W-1:0]       r_addr;
  logic [DATA_W-1:0]       r_wdata;
  logic [NUM_AGENTS-1:0]   r_ack;
  logic                    r_rd_valid;
  logic [AID_W-1:0]        r_rd_agent;
  logic [DATA_W-1:0]       r_rd_data;
  logic [BE_W-1:0]         r_be_n;
  logic                    r_ce_n;
  logic                    r_oe_n;
  logic                    r_we_n;
  logic                    r_dq_oe;

  state_t                  w_state_next;
  logic [CNT_W-1:0]        w_cnt_next;
  logic                    w_grant_fire;
  logic                    w_capture;
  logic [NUM_AGENTS-1:0]   w_req;
  logic [NUM_AGENTS-1:0]   w_grant;
  logic [AID_W-1:0]        w_gnt_idx;
  logic [ADDR_W-1:0]       w_sel_addr;
  logic [DATA_W-1:0]       w_sel_wdata;
  logic [BE_W-1:0]         w_sel_be;
  logic                    w_sel_wr;
  logic [BE_W-1:0]         w_be_next;
  logic                    w_active_next;

  logic [ADDR_W-1:0]       w_addr_arr  [NUM_AGENTS];
  logic [DATA_W-1:0]       w_wdata_arr [NUM_AGENTS];
  logic [BE_W-1:0]         w_be_arr    [NUM_AGENTS];

  for (genvar gi = 0; gi < NUM_AGENTS; gi++) begin : g_agt
    assign w_addr_arr[gi]  = agt_addr_i[gi*ADDR_W +: ADDR_W];
    assign w_wdata_arr[gi] = agt_wdata_i[gi*DATA_W +: DATA_W];
    assign w_be_arr[gi]    = agt_be_i[gi*BE_W +: BE_W];
  end

  assign w_req = agt_rd_en_i | agt_wr_en_i;

  syn_rr_arbiter #(
    .NUM_AGENTS (NUM_AGENTS),
    .PTR_W      (AID_W)
  ) u_arb (
    .i_req   (w_req),
    .i_ptr   (r_ptr),
    .o_grant (w_grant)
  );

  // Write wins over read for the same agent; its read stays pending for a later grant.
  always_comb begin
    w_gnt_idx   = '0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_be    = '0;
    w_sel_wr    = 1'b0;
    for (int i = 0; i < NUM_AGENTS; i++) begin
      if (w_grant[i]) begin
        w_gnt_idx   = AID_W'(i);
        w_sel_addr  = w_addr_arr[i];
        w_sel_wdata = w_wdata_arr[i];
        w_sel_be    = w_be_arr[i];
        w_sel_wr    = agt_wr_en_i[i];
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_grant_fire = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      IDLE: begin
        if (|w_grant) begin
          w_grant_fire = 1'b1;
          w_cnt_next   = '0;
          w_state_next = w_sel_wr ? WR : RD;
        end
      end
      RD: begin
        if (r_cnt == CNT_W'(RD_CYCLES - 1)) begin
          w_capture    = 1'b1;
          w_state_next = POST_ACCESS;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      WR: begin
        if (r_cnt == CNT_W'(WR_CYCLES - 1)) begin
          w_state_next = WR_HOLD;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      WR_HOLD: w_state_next = POST_ACCESS;
      TURN:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Pins are decoded from the next state so every output comes straight from a flop.
  assign w_be_next     = w_grant_fire ? w_sel_be : r_be;
  assign w_active_next = (w_state_next == RD) || (w_state_next == WR) || (w_state_next == WR_HOLD);

  always_ff @(posedge clk_ir) begin
    if (rst_il) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_ptr      <= '0;
      r_agent    <= '0;
      r_be       <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_ack      <= '0;
      r_rd_valid <= 1'b0;
      r_rd_agent <= '0;
      r_rd_data  <= '0;
      r_be_n     <= '1;
      r_ce_n     <= 1'b1;
      r_oe_n     <= 1'b1;
      r_we_n     <= 1'b1;
      r_dq_oe    <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_ack      <= w_grant_fire ? w_grant : '0;
      r_rd_valid <= w_capture;
      if (w_grant_fire) begin
        r_ptr   <= (int'(w_gnt_idx) == NUM_AGENTS - 1) ? '0 : w_gnt_idx + 1'b1;
        r_agent <= w_gnt_idx;
        r_addr  <= w_sel_addr;
        r_wdata <= w_sel_wdata;
        r_be    <= w_sel_be;
      end
      if (w_capture) begin
        r_rd_data  <= sram_dq_i;
        r_rd_agent <= r_agent;
      end
      r_ce_n  <= !w_active_next;
      r_oe_n  <= !(w_state_next == RD);
      r_we_n  <= !(w_state_next == WR);
      r_dq_oe <= (w_state_next == WR) || (w_state_next == WR_HOLD);
      r_be_n  <= w_active_next ? ~w_be_next : '1;
    end
  end

  assign agt_ack_o    = r_ack;
  assign rd_valid_o   = r_rd_valid;
  assign rd_agent_o   = r_rd_agent;
  assign rd_data_o    = r_rd_data;
  assign SRAM_ADDR    = r_addr;
  assign SRAM_BE_N    = r_be_n;
  assign SRAM_CE_N    = r_ce_n;
  assign SRAM_OE_N    = r_oe_n;
  assign SRAM_WE_N    = r_we_n;
  assign sram_dq_o    = r_wdata;
  assign sram_dq_oe_o = r_dq_oe;

endmodule

// File: tb/tb_syn_sram_mem_ctrl.sv
// Directed self-checking bench for syn_sram_mem_ctrl with a small byte-masked SRAM model.
module tb_syn_sram_mem_ctrl;

  localparam int N   = 2;
  localparam int AW  = 18;
  localparam int DW  = 16;
  localparam int BW  = 2;
  localparam int RDC = 2;
  localparam int WRC = 2;
`ifdef SYN_SRAM_MEM_CTRL_TURNAROUND_EN
  localparam int TURN_C = 1;
`else
  localparam int TURN_C = 0;
`endif

  logic            clk_ir = 1'b0;
  logic            rst_il = 1'b1;
  logic [N-1:0]    agt_rd_en_i = '0;
  logic [N-1:0]    agt_wr_en_i = '0;
  logic [N*AW-1:0] agt_addr_i = '0;
  logic [N*DW-1:0] agt_wdata_i = '0;
  logic [N*BW-1:0] agt_be_i = '0;
  logic [N-1:0]    agt_ack_o;
  logic            rd_valid_o;
  logic [0:0]      rd_agent_o;
  logic [DW-1:0]   rd_data_o;
  logic [AW-1:0]   SRAM_ADDR;
  logic [BW-1:0]   SRAM_BE_N;
  logic            SRAM_CE_N, SRAM_OE_N, SRAM_WE_N;
  logic [DW-1:0]   sram_dq_o;
  logic            sram_dq_oe_o;
  logic [DW-1:0]   sram_dq_i;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk_ir = ~clk_ir;

  syn_sram_mem_ctrl #(
    .NUM_AGENTS (N), .ADDR_W (AW), .DATA_W (DW), .RD_CYCLES (RDC), .WR_CYCLES (WRC)
  ) dut (
    .clk_ir       (clk_ir),
    .rst_il       (rst_il),
    .agt_rd_en_i  (agt_rd_en_i),
    .agt_wr_en_i  (agt_wr_en_i),
    .agt_addr_i   (agt_addr_i),
    .agt_wdata_i  (agt_wdata_i),
    .agt_be_i     (agt_be_i),
    .agt_ack_o    (agt_ack_o),
    .rd_valid_o   (rd_valid_o),
    .rd_agent_o   (rd_agent_o),
    .rd_data_o    (rd_data_o),
    .SRAM_ADDR    (SRAM_ADDR),
    .SRAM_BE_N    (SRAM_BE_N),
    .SRAM_CE_N    (SRAM_CE_N),
    .SRAM_OE_N    (SRAM_OE_N),
    .SRAM_WE_N    (SRAM_WE_N),
    .sram_dq_o    (sram_dq_o),
    .sram_dq_oe_o (sram_dq_oe_o),
    .sram_dq_i    (sram_dq_i)
  );

  // SRAM model: 1K words indexed by low address bits, byte-masked writes while WE_N is low.
  logic [DW-1:0] mem [0:1023];
  logic          pl_en = 1'b0;
  logic [9:0]    pl_addr = '0;
  logic [DW-1:0] pl_data = '0;

  always_comb sram_dq_i = (!SRAM_CE_N && !SRAM_OE_N) ? mem[SRAM_ADDR[9:0]] : 16'h0000;

  always @(posedge clk_ir) begin
    if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (!SRAM_CE_N && !SRAM_WE_N) begin
      for (int b = 0; b < BW; b++)
        if (!SRAM_BE_N[b]) mem[SRAM_ADDR[9:0]][b*8 +: 8] <= sram_dq_o[b*8 +: 8];
    end
  end

  always @(negedge clk_ir) begin
    if (|agt_ack_o) $display("[%0t] ack  vec=%b addr=%h", $time, agt_ack_o, SRAM_ADDR);
    if (rd_valid_o) $display("[%0t] rd   agent=%0d data=%h", $time, rd_agent_o, rd_data_o);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic preload(input logic [9:0] a, input logic [DW-1:0] d);
    pl_addr = a; pl_data = d; pl_en = 1'b1;
    @(negedge clk_ir);
    pl_en = 1'b0;
  endtask

  task automatic set_agent(input int n, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [BW-1:0] be);
    agt_addr_i[n*AW +: AW]  = a;
    agt_wdata_i[n*DW +: DW] = d;
    agt_be_i[n*BW +: BW]    = be;
  endtask

  task automatic test_reset();
    rst_il = 1'b1;
    repeat (3) @(negedge clk_ir);
    n_total++; if ({SRAM_CE_N, SRAM_OE_N, SRAM_WE_N} !== 3'b111) $display("FAIL rst_strobes: got %b want 111", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N}); else n_pass++;
    n_total++; if (SRAM_BE_N !== 2'b11) $display("FAIL rst_be_n: got %b want 11", SRAM_BE_N); else n_pass++;
    n_total++; if (SRAM_ADDR !== 18'h0) $display("FAIL rst_addr: got %h want 0", SRAM_ADDR); else n_pass++;
    n_total++; if ({sram_dq_oe_o, sram_dq_o} !== 17'h0) $display("FAIL rst_dq: got oe=%b dq=%h want 0/0", sram_dq_oe_o, sram_dq_o); else n_pass++;
    n_total++; if ({agt_ack_o, rd_valid_o, rd_agent_o} !== 4'b0) $display("FAIL rst_ack_valid: got %b want 0000", {agt_ack_o, rd_valid_o, rd_agent_o}); else n_pass++;
    n_total++; if (rd_data_o !== 16'h0) $display("FAIL rst_rd_data: got %h want 0", rd_data_o); else n_pass++;
    rst_il = 1'b0;
    @(negedge clk_ir);
  endtask

  task automatic test_single_read();
    int ack_cyc = -1, valid_cyc = -1, ce_cnt = 0, oe_cnt = 0, drv_cnt = 0;
    logic [N-1:0] ack_val = '0;
    logic [AW-1:0] seen_addr = '0;
    logic [BW-1:0] seen_be_n = '1;
    logic [DW-1:0] vdata = '0;
    logic [0:0] vagent = 1'b1;
    preload(10'h345, 16'hBEEF);
    set_agent(0, 18'h12345, 16'h0, 2'b11);
    agt_rd_en_i[0] = 1'b1;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk_ir);
      if (|agt_ack_o && ack_cyc < 0) begin ack_cyc = cyc; ack_val = agt_ack_o; agt_rd_en_i[0] = 1'b0; end
      if (!SRAM_CE_N) begin ce_cnt++; seen_addr = SRAM_ADDR; seen_be_n = SRAM_BE_N; end
      if (!SRAM_OE_N) oe_cnt++;
      if (sram_dq_oe_o) drv_cnt++;
      if (rd_valid_o) begin valid_cyc = cyc; vdata = rd_data_o; vagent = rd_agent_o; end
    end
    n_total++; if (ack_cyc !== 1 || ack_val !== 2'b01) $display("FAIL rd_ack: got cyc=%0d vec=%b want 1/01", ack_cyc, ack_val); else n_pass++;
    n_total++; if (ce_cnt !== RDC || oe_cnt !== RDC) $display("FAIL rd_strobe_len: got ce=%0d oe=%0d want %0d", ce_cnt, oe_cnt, RDC); else n_pass++;
    n_total++; if (seen_addr !== 18'h12345 || seen_be_n !== 2'b00) $display("FAIL rd_addr_be: got %h/%b want 12345/00", seen_addr, seen_be_n); else n_pass++;
    n_total++; if (drv_cnt !== 0) $display("FAIL rd_no_drive: got %0d want 0", drv_cnt); else n_pass++;
    n_total++; if (valid_cyc !== RDC + 1) $display("FAIL rd_valid_cyc: got %0d want %0d", valid_cyc, RDC + 1); else n_pass++;
    n_total++; if (vdata !== 16'hBEEF || vagent !== 1'b0) $display("FAIL rd_data: got %h agent %0d want BEEF agent 0", vdata, vagent); else n_pass++;
  endtask

  task automatic test_single_write();
    int ack_cyc = -1, we_cnt = 0, drv_cnt = 0, ce_cnt = 0, oe_cnt = 0;
    logic [N-1:0] ack_val = '0;
    logic [BW-1:0] seen_be_n = '0;
    logic [DW-1:0] seen_dq = '0;
    preload(10'h010, 16'h7700);
    set_agent(1, 18'h00010, 16'hA5C3, 2'b01);
    agt_wr_en_i[1] = 1'b1;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk_ir);
      if (|agt_ack_o && ack_cyc < 0) begin ack_cyc = cyc; ack_val = agt_ack_o; agt_wr_en_i[1] = 1'b0; end
      if (!SRAM_WE_N) begin we_cnt++; seen_be_n = SRAM_BE_N; seen_dq = sram_dq_o; end
      if (sram_dq_oe_o) drv_cnt++;
      if (!SRAM_CE_N) ce_cnt++;
      if (!SRAM_OE_N) oe_cnt++;
    end
    n_total++; if (ack_cyc !== 1 || ack_val !== 2'b10) $display("FAIL wr_ack: got cyc=%0d vec=%b want 1/10", ack_cyc, ack_val); else n_pass++;
    n_total++; if (we_cnt !== WRC || oe_cnt !== 0) $display("FAIL wr_we_len: got we=%0d oe=%0d want %0d/0", we_cnt, oe_cnt, WRC); else n_pass++;
    n_total++; if (drv_cnt !== WRC + 1 || ce_cnt !== WRC + 1) $display("FAIL wr_drive_len: got oe=%0d ce=%0d want %0d", drv_cnt, ce_cnt, WRC + 1); else n_pass++;
    n_total++; if (seen_be_n !== 2'b10 || seen_dq !== 16'hA5C3) $display("FAIL wr_be_dq: got %b/%h want 10/A5C3", seen_be_n, seen_dq); else n_pass++;
    n_total++; if (mem[10'h010] !== 16'h77C3) $display("FAIL wr_mem: got %h want 77C3", mem[10'h010]); else n_pass++;
  endtask

  task automatic test_round_robin();
    localparam int EXP_ACKS = 11 / (RDC + 1 + TURN_C) + 1;
    int seq [8];
    int n_ack = 0, viol = 0;
    for (int i = 0; i < 8; i++) seq[i] = 9;
    set_agent(0, 18'h00100, 16'h0, 2'b11);
    set_agent(1, 18'h00101, 16'h0, 2'b11);
    agt_rd_en_i = 2'b11;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk_ir);
      if (|agt_ack_o) begin
        seq[n_ack % 8] = (agt_ack_o == 2'b01) ? 0 : (agt_ack_o == 2'b10) ? 1 : 7;
        n_ack++;
      end
      if (!SRAM_OE_N && !SRAM_WE_N) viol++;
      if (sram_dq_oe_o && (!SRAM_OE_N || SRAM_CE_N)) viol++;
    end
    agt_rd_en_i = '0;
    n_total++; if (n_ack !== EXP_ACKS) $display("FAIL rr_ack_count: got %0d want %0d", n_ack, EXP_ACKS); else n_pass++;
    for (int i = 0; i < EXP_ACKS; i++) begin
      n_total++; if (seq[i] !== i % 2) $display("FAIL rr_order[%0d]: got agent %0d want %0d", i, seq[i], i % 2); else n_pass++;
    end
    n_total++; if (viol !== 0) $display("FAIL rr_pin_rules: got %0d violations want 0", viol); else n_pass++;
    repeat (8) @(negedge clk_ir);
  endtask

  task automatic test_dual_request();
    int n_ack = 0, ack2_cyc = -1, first_we = -1, first_oe = -1;
    logic [DW-1:0] vdata = '0;
    logic [0:0] vagent = 1'b1;
    preload(10'h200, 16'hFFFF);
    set_agent(0, 18'h00200, 16'h1234, 2'b11);
    agt_rd_en_i[0] = 1'b1;
    agt_wr_en_i[0] = 1'b1;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      @(negedge clk_ir);
      if (agt_ack_o[0]) begin
        n_ack++;
        if (n_ack == 1) agt_wr_en_i[0] = 1'b0;
        if (n_ack == 2) begin agt_rd_en_i[0] = 1'b0; ack2_cyc = cyc; end
      end
      if (!SRAM_WE_N && first_we < 0) first_we = cyc;
      if (!SRAM_OE_N && first_oe < 0) first_oe = cyc;
      if (rd_valid_o) begin vdata = rd_data_o; vagent = rd_agent_o; end
    end
    n_total++; if (n_ack !== 2) $display("FAIL dual_acks: got %0d want 2", n_ack); else n_pass++;
    n_total++; if (first_we !== 1 || first_oe <= first_we) $display("FAIL dual_order: got we@%0d oe@%0d want write first", first_we, first_oe); else n_pass++;
    n_total++; if (ack2_cyc !== WRC + 3 + TURN_C) $display("FAIL dual_wr_period: got %0d want %0d", ack2_cyc, WRC + 3 + TURN_C); else n_pass++;
    n_total++; if (vdata !== 16'h1234 || vagent !== 1'b0) $display("FAIL dual_rd_data: got %h agent %0d want 1234 agent 0", vdata, vagent); else n_pass++;
  endtask

  task automatic test_reset_mid_write();
    int first_ack_cyc = -1;
    logic [N-1:0] first_ack = '0;
    set_agent(0, 18'h00030, 16'h0F0F, 2'b11);
    agt_wr_en_i[0] = 1'b1;
    @(negedge clk_ir);
    n_total++; if (agt_ack_o !== 2'b01) $display("FAIL rmw_ack: got %b want 01", agt_ack_o); else n_pass++;
    agt_wr_en_i[0] = 1'b0;
    @(negedge clk_ir);
    n_total++; if (SRAM_WE_N !== 1'b0) $display("FAIL rmw_in_write: got we_n=%b want 0", SRAM_WE_N); else n_pass++;
    rst_il = 1'b1;
    @(negedge clk_ir);
    n_total++; if ({SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_BE_N} !== 5'b11111) $display("FAIL rmw_strobes: got %b want 11111", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_BE_N}); else n_pass++;
    n_total++; if ({sram_dq_oe_o, agt_ack_o, rd_valid_o} !== 4'b0) $display("FAIL rmw_quiet: got %b want 0000", {sram_dq_oe_o, agt_ack_o, rd_valid_o}); else n_pass++;
    n_total++; if (SRAM_ADDR !== 18'h0) $display("FAIL rmw_addr: got %h want 0", SRAM_ADDR); else n_pass++;
    rst_il = 1'b0;
    set_agent(0, 18'h00100, 16'h0, 2'b11);
    set_agent(1, 18'h00101, 16'h0, 2'b11);
    agt_rd_en_i = 2'b11;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk_ir);
      if (|agt_ack_o && first_ack_cyc < 0) begin first_ack_cyc = cyc; first_ack = agt_ack_o; agt_rd_en_i = '0; end
    end
    agt_rd_en_i = '0;
    n_total++; if (first_ack_cyc !== 1 || first_ack !== 2'b01) $display("FAIL rmw_ptr_restart: got cyc=%0d vec=%b want 1/01", first_ack_cyc, first_ack); else n_pass++;
    repeat (6) @(negedge clk_ir);
  endtask

  task automatic test_turnaround();
    int n_ack = 0, hold_cyc = -1, rd_cyc = -1, gap = 0, bad = 0;
    logic [DW-1:0] vdata = '0;
    set_agent(0, 18'h00040, 16'hCAFE, 2'b11);
    agt_wr_en_i[0] = 1'b1;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      @(negedge clk_ir);
      if (agt_ack_o[0]) begin
        n_ack++;
        if (n_ack == 1) begin agt_wr_en_i[0] = 1'b0; agt_rd_en_i[0] = 1'b1; end
        if (n_ack == 2) agt_rd_en_i[0] = 1'b0;
      end
      if (!SRAM_CE_N && SRAM_WE_N && sram_dq_oe_o) hold_cyc = cyc;
      if (!SRAM_OE_N && rd_cyc < 0) rd_cyc = cyc;
      if (hold_cyc >= 0 && rd_cyc < 0 && SRAM_CE_N) begin
        gap++;
        if (!SRAM_OE_N || !SRAM_WE_N || sram_dq_oe_o || SRAM_BE_N !== 2'b11) bad++;
      end
      if (rd_valid_o) vdata = rd_data_o;
    end
    n_total++; if (gap !== 1 + TURN_C) $display("FAIL turn_gap: got %0d idle cycles want %0d", gap, 1 + TURN_C); else n_pass++;
    n_total++; if (bad !== 0) $display("FAIL turn_bus_idle: got %0d bad cycles want 0", bad); else n_pass++;
    n_total++; if (vdata !== 16'hCAFE) $display("FAIL turn_rd_data: got %h want CAFE", vdata); else n_pass++;
  endtask

  task automatic test_be_zero();
    int we_cnt = 0;
    logic [BW-1:0] seen_be_n = '0;
    preload(10'h050, 16'h5555);
    set_agent(1, 18'h00050, 16'hAAAA, 2'b00);
    agt_wr_en_i[1] = 1'b1;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk_ir);
      if (agt_ack_o[1]) agt_wr_en_i[1] = 1'b0;
      if (!SRAM_WE_N) begin we_cnt++; seen_be_n = SRAM_BE_N; end
    end
    agt_wr_en_i = '0;
    n_total++; if (we_cnt !== WRC || seen_be_n !== 2'b11) $display("FAIL be0_access: got we=%0d be_n=%b want %0d/11", we_cnt, seen_be_n, WRC); else n_pass++;
    n_total++; if (mem[10'h050] !== 16'h5555) $display("FAIL be0_mem: got %h want 5555", mem[10'h050]); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_round_robin();
    test_dual_request();
    test_reset_mid_write();
    test_turnaround();
    test_be_zero();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
